id_exe_hazard_reg: RTL and testbench
====================================

ID_EXE_HAZARD_REG -- requirements
Module: id_exe_hazard_reg

Interface
REQ-001 Parameter DATA_W, default 16, operand/immediate datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_rs, id_rt, id_rd  input  5 each  register indices of instruction in ID.
REQ-005 id_rdata_1, id_rdata_2, id_imm  input  DATA_W each  regfile read data and sign-extended immediate from ID.
REQ-006 id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  input  1 each  decoded control from ID.
REQ-007 id_alu_op  input  4  ALU operation from ID.
REQ-008 flush  input  1  taken branch/jump; squash the ID instruction.
REQ-009 hold  input  1  downstream memory wait; freeze this stage.
REQ-010 exe_rs, exe_rt, exe_rd  output  5 each  registered indices; exe_rs/exe_rt feed the forwarding unit Rs/Rt inputs.
REQ-011 exe_rdata_1, exe_rdata_2, exe_imm  output  DATA_W each  registered operands.
REQ-012 exe_reg_write, exe_mem_to_reg, exe_mem_read, exe_mem_write, exe_alu_src, exe_reg_dst  output  1 each; exe_alu_op output 4.
REQ-013 exe_valid  output  1  EX slot holds a real instruction.
REQ-014 pc_write, if_id_write  output  1 each  combinational enables to PC and IF/ID register; 0 = stall.
REQ-015 stall_count, bubble_count  output  16 each  performance counters.

Function
REQ-016 Load-use hazard lu = exe_valid & exe_mem_read & (exe_rt != 0) & (exe_rt == id_rs | exe_rt == id_rt).
REQ-017 pc_write = if_id_write = !(lu | hold), combinational, same cycle.
REQ-018 Per-edge priority SHALL be: rst > flush > hold > lu > load.
REQ-019 flush: all outputs registered to zero, exe_valid=0, regardless of hold.
REQ-020 hold (no flush): every registered output keeps its value.
REQ-021 lu (no flush/hold): bubble -- control outputs and exe_alu_op zeroed, exe_valid=0; index/data fields zeroed.
REQ-022 load: all id_* captured into exe_*, exe_valid=1; latency exactly one cycle.
REQ-023 A bubble-producing stall SHALL last exactly one cycle per load (bubble clears lu next cycle).
REQ-024 Bubble/flush SHALL never assert exe_reg_write or exe_mem_write.
REQ-025 stall_count increments by 1 each cycle with (lu | hold) and !flush; saturates at 16'hFFFF.
REQ-026 bubble_count increments by 1 each cycle a bubble is inserted per REQ-021; saturates at 16'hFFFF.
REQ-027 Index 0 never triggers lu, even if exe_mem_read=1.
REQ-028 lu and flush in same cycle: flush wins, pc_write still 0 that cycle (combinational), no bubble counted.

Reset
REQ-029 On rst all registered outputs, exe_valid, stall_count, bubble_count SHALL be 0 at the next edge.
REQ-030 rst asserted mid-hold or mid-stall SHALL override both; first post-reset cycle has pc_write=1 unless hold.

Structure
REQ-031 Shared pipeline package SHALL hold control-bundle field widths, ALU_OP_W=4, REG_IDX_W=5, and zero-bubble constant.
REQ-032 One sub-module hazard_detect (combinational lu computation, REQ-016/027) SHALL be instantiated.
REQ-033 Counters SHALL be saturating, no wrap.

Verification
REQ-034 Load: id_rs=3,id_rt=4,id_rdata_1=16'h1234, no hazard -> next cycle exe_rs=3, exe_rdata_1=16'h1234, exe_valid=1.
REQ-035 Load-use: EX holds lw exe_rt=5, ID id_rs=5 -> pc_write=0 one cycle, next cycle exe_valid=0, exe_reg_write=0, bubble_count=1, then normal load.
REQ-036 exe_rt=0 with exe_mem_read=1 and id_rs=0 -> no stall, pc_write=1.
REQ-037 hold=1 for 3 cycles with changing id_* -> exe_* unchanged, stall_count=3; flush during hold -> zeros next edge.
REQ-038 Simultaneous lu and flush -> exe_valid=0, bubble_count unchanged.
REQ-039 Force 65536 stall cycles -> stall_count holds 16'hFFFF; rst -> all outputs 0 next edge.

Source files
------------

// File: rtl/id_exe_hazard_reg_pkg.sv
// Shared ID/EX pipeline definitions: field widths, control bundle, bubble constant
// and the per-edge stage action decode.
package id_exe_hazard_reg_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned CNT_W     = 16;

  // Decoded control travelling alongside the instruction.
  typedef struct packed {
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic                reg_dst;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  // A bubble is a NOP: nothing written to the regfile or memory.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // What the stage register does at the next edge (reset handled separately).
  typedef enum logic [1:0] {
    ActLoad,
    ActBubble,
    ActHold,
    ActFlush
  } stage_act_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

endpackage

// File: rtl/id_exe_hazard_reg_hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose destination
// (rt) is a source of the instruction in ID. Register 0 never creates a hazard.
module id_exe_hazard_reg_hazard_detect
  import id_exe_hazard_reg_pkg::*;
(
  input  logic                 exe_valid,
  input  logic                 exe_mem_read,
  input  logic [REG_IDX_W-1:0] exe_rt,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  output logic                 lu
);

  logic rt_nonzero;
  logic src_match;

  // Combinational hazard compare.
  always_comb begin
    rt_nonzero = |exe_rt;
    src_match  = (exe_rt == id_rs) || (exe_rt == id_rt);
    lu         = exe_valid & exe_mem_read & rt_nonzero & src_match;
  end

endmodule

// File: rtl/id_exe_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and
// saturating stall/bubble performance counters.
module id_exe_hazard_reg
  import id_exe_hazard_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic [DATA_W-1:0]    id_rdata_1,
  input  logic [DATA_W-1:0]    id_rdata_2,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic                 id_reg_write,
  input  logic                 id_mem_to_reg,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic                 id_alu_src,
  input  logic                 id_reg_dst,
  input  logic [ALU_OP_W-1:0]  id_alu_op,
  input  logic                 flush,
  input  logic                 hold,
  output logic [REG_IDX_W-1:0] exe_rs,
  output logic [REG_IDX_W-1:0] exe_rt,
  output logic [REG_IDX_W-1:0] exe_rd,
  output logic [DATA_W-1:0]    exe_rdata_1,
  output logic [DATA_W-1:0]    exe_rdata_2,
  output logic [DATA_W-1:0]    exe_imm,
  output logic                 exe_reg_write,
  output logic                 exe_mem_to_reg,
  output logic                 exe_mem_read,
  output logic                 exe_mem_write,
  output logic                 exe_alu_src,
  output logic                 exe_reg_dst,
  output logic [ALU_OP_W-1:0]  exe_alu_op,
  output logic                 exe_valid,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     bubble_count
);

  logic [REG_IDX_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0]    rdata_1_q, rdata_1_d, rdata_2_q, rdata_2_d, imm_q, imm_d;
  ctrl_t                ctrl_q, ctrl_d, id_ctrl;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic                 lu;
  stage_act_e           act;

  id_exe_hazard_reg_hazard_detect u_hazard_detect (
    .exe_valid    (valid_q),
    .exe_mem_read (ctrl_q.mem_read),
    .exe_rt       (rt_q),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .lu           (lu)
  );

  // Gather the decoded ID control into one bundle.
  always_comb begin
    id_ctrl            = CTRL_BUBBLE;
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.reg_dst    = id_reg_dst;
    id_ctrl.alu_op     = id_alu_op;
  end

  // Decide the stage action: flush beats hold beats load-use beats load.
  always_comb begin
    act = ActLoad;
    if (flush) begin
      act = ActFlush;
    end else if (hold) begin
      act = ActHold;
    end else if (lu) begin
      act = ActBubble;
    end
  end

  // Stall the front end while a bubble is being inserted or memory is busy.
  // A flush does not release the stall in the same cycle.
  always_comb begin
    pc_write    = ~(lu | hold);
    if_id_write = ~(lu | hold);
  end

  // Next-state for the pipeline payload.
  always_comb begin
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    rdata_1_d = rdata_1_q;
    rdata_2_d = rdata_2_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    unique case (act)
      ActFlush, ActBubble: begin
        // Both squash to an all-zero NOP; index fields cleared so no stale forwarding.
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        rdata_1_d = '0;
        rdata_2_d = '0;
        imm_d     = '0;
        ctrl_d    = CTRL_BUBBLE;
        valid_d   = 1'b0;
      end
      ActHold: begin
        // Keep everything as is.
      end
      ActLoad: begin
        rs_d      = id_rs;
        rt_d      = id_rt;
        rd_d      = id_rd;
        rdata_1_d = id_rdata_1;
        rdata_2_d = id_rdata_2;
        imm_d     = id_imm;
        ctrl_d    = id_ctrl;
        valid_d   = 1'b1;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  // Next-state for the saturating performance counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((lu | hold) && !flush) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (act == ActBubble) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  // Stage and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rdata_1_q    <= '0;
      rdata_2_q    <= '0;
      imm_q        <= '0;
      ctrl_q       <= CTRL_BUBBLE;
      valid_q      <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      rdata_1_q    <= rdata_1_d;
      rdata_2_q    <= rdata_2_d;
      imm_q        <= imm_d;
      ctrl_q       <= ctrl_d;
      valid_q      <= valid_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Drive outputs straight from the registers.
  always_comb begin
    exe_rs         = rs_q;
    exe_rt         = rt_q;
    exe_rd         = rd_q;
    exe_rdata_1    = rdata_1_q;
    exe_rdata_2    = rdata_2_q;
    exe_imm        = imm_q;
    exe_reg_write  = ctrl_q.reg_write;
    exe_mem_to_reg = ctrl_q.mem_to_reg;
    exe_mem_read   = ctrl_q.mem_read;
    exe_mem_write  = ctrl_q.mem_write;
    exe_alu_src    = ctrl_q.alu_src;
    exe_reg_dst    = ctrl_q.reg_dst;
    exe_alu_op     = ctrl_q.alu_op;
    exe_valid      = valid_q;
    stall_count    = stall_cnt_q;
    bubble_count   = bubble_cnt_q;
  end

endmodule

// File: tb/tb_id_exe_hazard_reg.sv
// Self-checking bench for id_exe_hazard_reg: directed scenarios plus randomized
// traffic against a behavioural model of the ID/EX stage.
module tb_id_exe_hazard_reg;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rdata_1, id_rdata_2, id_imm;
  logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst;
  logic [3:0]  id_alu_op;
  logic        flush, hold;
  logic [4:0]  exe_rs, exe_rt, exe_rd;
  logic [15:0] exe_rdata_1, exe_rdata_2, exe_imm;
  logic        exe_reg_write, exe_mem_to_reg, exe_mem_read, exe_mem_write, exe_alu_src;
  logic        exe_reg_dst;
  logic [3:0]  exe_alu_op;
  logic        exe_valid, pc_write, if_id_write;
  logic [15:0] stall_count, bubble_count;

  int checks = 0;
  int errors = 0;

  id_exe_hazard_reg #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata_1(id_rdata_1), .id_rdata_2(id_rdata_2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_op(id_alu_op), .flush(flush), .hold(hold),
    .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_rd(exe_rd),
    .exe_rdata_1(exe_rdata_1), .exe_rdata_2(exe_rdata_2), .exe_imm(exe_imm),
    .exe_reg_write(exe_reg_write), .exe_mem_to_reg(exe_mem_to_reg),
    .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write), .exe_alu_src(exe_alu_src),
    .exe_reg_dst(exe_reg_dst), .exe_alu_op(exe_alu_op), .exe_valid(exe_valid),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_count(stall_count), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [73:0] got_vec;
  assign got_vec = {exe_rs, exe_rt, exe_rd, exe_rdata_1, exe_rdata_2, exe_imm,
                    exe_reg_write, exe_mem_to_reg, exe_mem_read, exe_mem_write,
                    exe_alu_src, exe_reg_dst, exe_alu_op, exe_valid};

  // Reference model: what the EX slot should contain, plus counter values.
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [15:0] m_d1, m_d2, m_imm;
  logic        m_rw, m_m2r, m_mr, m_mw, m_as, m_rdst, m_valid;
  logic [3:0]  m_op;
  int          m_stall = 0;
  int          m_bubble = 0;

  function automatic logic [73:0] exp_vec();
    return {m_rs, m_rt, m_rd, m_d1, m_d2, m_imm, m_rw, m_m2r, m_mr, m_mw, m_as, m_rdst,
            m_op, m_valid};
  endfunction

  // A load in EX whose nonzero destination is read by the ID instruction.
  function automatic bit model_lu();
    return m_valid && m_mr && (m_rt != 0) && ((m_rt == id_rs) || (m_rt == id_rt));
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_clear();
    {m_rs, m_rt, m_rd, m_d1, m_d2, m_imm, m_rw, m_m2r, m_mr, m_mw, m_as, m_rdst, m_op,
     m_valid} = '0;
  endtask

  // Apply one clock edge to the model using the current inputs.
  task automatic model_edge();
    bit lu_now;
    lu_now = model_lu();
    if (rst) begin
      model_clear();
      m_stall  = 0;
      m_bubble = 0;
    end else if (flush) begin
      model_clear();
    end else if (hold) begin
      m_stall = sat16(m_stall + 1);
    end else if (lu_now) begin
      model_clear();
      m_stall  = sat16(m_stall + 1);
      m_bubble = sat16(m_bubble + 1);
    end else begin
      {m_rs, m_rt, m_rd} = {id_rs, id_rt, id_rd};
      {m_d1, m_d2, m_imm} = {id_rdata_1, id_rdata_2, id_imm};
      {m_rw, m_m2r, m_mr, m_mw, m_as, m_rdst} =
        {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst};
      m_op    = id_alu_op;
      m_valid = 1'b1;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; flush = 0; hold = 0;
    {id_rs, id_rt, id_rd, id_rdata_1, id_rdata_2, id_imm} = '0;
    {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst} = '0;
    id_alu_op = '0;
  endtask

  task automatic rand_id();
    id_rs = 5'($urandom_range(0, 7));
    id_rt = 5'($urandom_range(0, 7));
    id_rd = 5'($urandom);
    id_rdata_1 = 16'($urandom);
    id_rdata_2 = 16'($urandom);
    id_imm = 16'($urandom);
    {id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_dst} = 5'($urandom);
    id_mem_read = ($urandom_range(0, 1) == 0);
    id_alu_op = 4'($urandom);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    cycle();
    cycle();
    checks++;
    if (got_vec !== 74'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", got_vec);
    end
    checks++;
    if (stall_count !== 16'd0 || bubble_count !== 16'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_count, bubble_count);
    end
    rst = 0;
    #1;
    checks++;
    if (pc_write !== 1'b1 || if_id_write !== 1'b1) begin
      errors++; $display("FAIL reset_pc_write got %b/%b want 1/1", pc_write, if_id_write);
    end
  endtask

  task automatic test_load();
    set_idle();
    id_rs = 3; id_rt = 4; id_rd = 7; id_rdata_1 = 16'h1234; id_rdata_2 = 16'h0BEE;
    id_imm = 16'hFFF0; id_reg_write = 1; id_alu_op = 4'h2;
    #1;
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL load_pc_write got %b want 1", pc_write);
    end
    cycle();
    checks++;
    if (exe_rs !== 5'd3 || exe_rdata_1 !== 16'h1234 || exe_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_fields got rs=%0d d1=%h v=%b want rs=3 d1=1234 v=1",
               exe_rs, exe_rdata_1, exe_valid);
    end
    checks++;
    if (got_vec !== exp_vec()) begin
      errors++; $display("FAIL load_vec got %h want %h", got_vec, exp_vec());
    end
  endtask

  task automatic test_load_use();
    set_idle();
    id_rt = 5; id_rs = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    cycle();
    set_idle();
    id_rs = 5; id_rt = 9; id_rd = 10; id_rdata_1 = 16'hAAAA; id_reg_write = 1;
    #1;
    checks++;
    if (pc_write !== 1'b0 || if_id_write !== 1'b0) begin
      errors++; $display("FAIL lu_stall got %b/%b want 0/0", pc_write, if_id_write);
    end
    cycle();
    checks++;
    if (exe_valid !== 1'b0 || exe_reg_write !== 1'b0 || exe_mem_write !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble got v=%b rw=%b mw=%b want 0/0/0",
               exe_valid, exe_reg_write, exe_mem_write);
    end
    checks++;
    if (bubble_count !== 16'd1) begin
      errors++; $display("FAIL lu_bubble_count got %0d want 1", bubble_count);
    end
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL lu_one_cycle got pc_write=%b want 1", pc_write);
    end
    cycle();
    checks++;
    if (exe_valid !== 1'b1 || exe_rs !== 5'd5 || exe_rdata_1 !== 16'hAAAA) begin
      errors++;
      $display("FAIL lu_reload got v=%b rs=%0d d1=%h want 1/5/aaaa", exe_valid, exe_rs, exe_rdata_1);
    end
  endtask

  task automatic test_zero_index();
    int b0;
    set_idle();
    id_rt = 0; id_mem_read = 1;
    cycle();
    set_idle();
    b0 = m_bubble;
    #1;
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL zero_idx_pc_write got %b want 1", pc_write);
    end
    cycle();
    checks++;
    if (exe_valid !== 1'b1 || bubble_count !== 16'(b0)) begin
      errors++;
      $display("FAIL zero_idx_no_bubble got v=%b bc=%0d want 1/%0d", exe_valid, bubble_count, b0);
    end
  endtask

  task automatic test_hold_flush();
    logic [73:0] snap;
    int s0;
    set_idle();
    id_rs = 12; id_rt = 13; id_rd = 14; id_rdata_2 = 16'h5A5A; id_mem_write = 1; id_alu_op = 4'h9;
    cycle();
    snap = got_vec;
    s0 = m_stall;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      hold = 1;
      #1;
      checks++;
      if (pc_write !== 1'b0) begin
        errors++; $display("FAIL hold_pc_write got %b want 0", pc_write);
      end
      cycle();
      checks++;
      if (got_vec !== snap || got_vec !== exp_vec()) begin
        errors++; $display("FAIL hold_frozen got %h want %h", got_vec, snap);
      end
    end
    checks++;
    if (stall_count !== 16'(s0 + 3)) begin
      errors++; $display("FAIL hold_stall_count got %0d want %0d", stall_count, s0 + 3);
    end
    flush = 1;
    cycle();
    checks++;
    if (got_vec !== 74'd0) begin
      errors++; $display("FAIL flush_in_hold got %h want 0", got_vec);
    end
    checks++;
    if (stall_count !== 16'(s0 + 3)) begin
      errors++; $display("FAIL flush_no_stall got %0d want %0d", stall_count, s0 + 3);
    end
  endtask

  task automatic test_lu_flush();
    int b0;
    set_idle();
    id_rt = 6; id_mem_read = 1; id_reg_write = 1;
    cycle();
    set_idle();
    id_rs = 6; id_reg_write = 1;
    flush = 1;
    b0 = m_bubble;
    #1;
    checks++;
    if (pc_write !== 1'b0) begin
      errors++; $display("FAIL lu_flush_pc_write got %b want 0", pc_write);
    end
    cycle();
    checks++;
    if (exe_valid !== 1'b0 || exe_reg_write !== 1'b0 || bubble_count !== 16'(b0)) begin
      errors++;
      $display("FAIL lu_flush got v=%b rw=%b bc=%0d want 0/0/%0d",
               exe_valid, exe_reg_write, bubble_count, b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rand_id();
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (pc_write !== !(model_lu() || hold) || if_id_write !== pc_write) begin
        errors++;
        $display("FAIL rand_pc_write[%0d] got %b/%b want %b", i, pc_write, if_id_write,
                 !(model_lu() || hold));
      end
      cycle();
      checks++;
      if (got_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_vec[%0d] got %h want %h", i, got_vec, exp_vec());
      end
      checks++;
      if (stall_count !== 16'(m_stall) || bubble_count !== 16'(m_bubble)) begin
        errors++;
        $display("FAIL rand_counters[%0d] got %0d/%0d want %0d/%0d", i, stall_count,
                 bubble_count, m_stall, m_bubble);
      end
    end
  endtask

  task automatic test_saturation();
    set_idle();
    hold = 1;
    for (int i = 0; i < 65540; i++) cycle();
    checks++;
    if (stall_count !== 16'hFFFF) begin
      errors++; $display("FAIL stall_saturate got %h want ffff", stall_count);
    end
    checks++;
    if (got_vec !== exp_vec()) begin
      errors++; $display("FAIL saturate_frozen got %h want %h", got_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_stall();
    // Reset during a long hold.
    rst = 1;
    hold = 1;
    cycle();
    checks++;
    if (got_vec !== 74'd0 || stall_count !== 16'd0 || bubble_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_hold got %h sc=%0d bc=%0d want 0", got_vec, stall_count, bubble_count);
    end
    rst = 0;
    #1;
    checks++;
    if (pc_write !== 1'b0) begin
      errors++; $display("FAIL rst_hold_pc_write got %b want 0", pc_write);
    end
    hold = 0;
    #1;
    checks++;
    if (pc_write !== 1'b1) begin
      errors++; $display("FAIL rst_post_pc_write got %b want 1", pc_write);
    end
    // Reset while a load-use stall is pending.
    set_idle();
    id_rt = 8; id_mem_read = 1;
    cycle();
    set_idle();
    id_rt = 8;
    rst = 1;
    cycle();
    rst = 0;
    #1;
    checks++;
    if (got_vec !== 74'd0 || pc_write !== 1'b1 || bubble_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_lu got %h pc=%b bc=%0d want 0/1/0", got_vec, pc_write, bubble_count);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_load_use();
    test_zero_index();
    test_hold_flush();
    test_lu_flush();
    test_random();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
